mix_scheduler: RTL and testbench

- Time-multiplexed 8-in × 8-out mixing-matrix controller on the oversampling clock (~98.304 MHz).
- On each frame strobe (data_request synchronised into clk domain), latches the ADAT input frame and sequences one shared multiplier through all N_IN×N_OUT gain products.
- Saturates and presents the mixed frame to the ADAT output path.
- Owns double-banked gain coefficients; host updates commit atomically at frame boundaries.

---
 rtl/mix_pkg.sv | 29 ++
 rtl/mix_mac.sv | 58 +++++
 rtl/mix_scheduler.sv | 154 +++++++++++++++
 tb/tb_mix_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared constants, types and FSM encoding for the 8x8 time-multiplexed mixing matrix.
package mix_pkg;

  localparam int N_IN  = 8;
  localparam int N_OUT = 8;
  localparam int W     = 24;
  localparam int CW    = 18;
  localparam int FRAC  = 16;
  localparam int AW    = W + CW + 3;
  localparam int CH_W  = $clog2(N_IN);
  localparam int BUS_W = $clog2(N_OUT);

  typedef logic signed [W-1:0]  sample_t;
  typedef logic signed [CW-1:0] gain_t;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (W - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (W - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

endpackage

// File: rtl/mix_mac.sv
// Shared multiply-accumulate datapath: 2-stage multiply pipe, wide accumulator,
// Q1.16 rescale and saturation to the sample range.
module mix_mac
  import mix_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0]  sample,
  input  logic signed [CW-1:0] gain,
  input  logic                acc_clr,
  output logic signed [W-1:0]  y,
  output logic                clip
);

  sample_t s_r;
  gain_t   g_r;
  acc_t    p_r;
  acc_t    acc;
  acc_t    sh;
  logic    v1;
  logic    v2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r <= '0;
      g_r <= '0;
      v1  <= 1'b0;
      p_r <= '0;
      v2  <= 1'b0;
      acc <= '0;
    end else begin
      s_r <= sample;
      g_r <= gain;
      v1  <= in_valid;
      p_r <= acc_t'(s_r) * acc_t'(g_r);
      v2  <= v1;
      if (acc_clr)
        acc <= '0;
      else if (v2)
        acc <= acc + p_r;
    end
  end

  always_comb begin
    sh   = acc >>> FRAC;
    y    = sh[W-1:0];
    clip = 1'b0;
    if (sh > SAT_MAX) begin
      y    = SAT_MAX[W-1:0];
      clip = 1'b1;
    end else if (sh < SAT_MIN) begin
      y    = SAT_MIN[W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// Mixing-matrix controller: frame FSM, double-banked gains, host handshake.
// Optional clip counter enabled by defining MIX_SCHEDULER_CLIP_COUNT_EN.
module mix_scheduler
  import mix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_strobe,
  input  logic [N_IN*W-1:0]    audio_in,
  output logic [N_OUT*W-1:0]   audio_out,
  output logic                 mix_valid,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 coef_wr_valid,
  output logic                 coef_wr_ready,
  input  logic [5:0]           coef_wr_addr,
  input  logic [CW-1:0]        coef_wr_data,
  input  logic                 coef_commit,
  output logic                 commit_pending
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
  ,
  output logic [15:0]          clip_count,
  input  logic                 clip_clear
`endif
);

  state_t           state, state_n;
  logic [CH_W-1:0]  cnt, cnt_n;
  logic [BUS_W-1:0] bus, bus_n;
  logic             issue, acc_clr, store, load;
  logic             active;
  sample_t          frame [N_IN];
  sample_t          out_r [N_OUT];
  gain_t            bank  [2][N_OUT*N_IN];
  sample_t          y;
  logic             clip;

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign mix_valid     = (state == S_DONE);
  assign coef_wr_ready = (state != S_LOAD);

  always_comb begin
    audio_out = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      audio_out[i*W +: W] = out_r[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bus   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bus   <= bus_n;
    end
  end

  // cnt walks the channels during MAC and is reused for the 2-cycle drain.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bus_n   = bus;
    issue   = 1'b0;
    acc_clr = 1'b0;
    store   = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: if (frame_strobe) state_n = S_LOAD;
      S_LOAD: begin
        load    = 1'b1;
        acc_clr = 1'b1;
        cnt_n   = '0;
        bus_n   = '0;
        state_n = S_MAC;
      end
      S_MAC: begin
        issue = 1'b1;
        if (cnt == CH_W'(N_IN - 1)) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == CH_W'(1)) begin
          cnt_n   = '0;
          state_n = S_STORE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STORE: begin
        store   = 1'b1;
        acc_clr = 1'b1;
        bus_n   = bus + 1'b1;
        state_n = (bus == BUS_W'(N_OUT - 1)) ? S_DONE : S_MAC;
      end
      S_DONE:  state_n = frame_strobe ? S_LOAD : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Host writes always land in the shadow bank, so a write coincident with a
  // commit is already in place when LOAD flips the active bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active         <= 1'b0;
      commit_pending <= 1'b0;
      overrun        <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) frame[i] <= '0;
      for (int unsigned i = 0; i < N_OUT; i++) out_r[i] <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < N_OUT*N_IN; i++) bank[b][i] <= '0;
    end else begin
      if (coef_wr_valid && coef_wr_ready)
        bank[~active][coef_wr_addr] <= coef_wr_data;
      if (load) begin
        if (commit_pending) active <= ~active;
        commit_pending <= coef_commit;
        for (int unsigned i = 0; i < N_IN; i++) frame[i] <= audio_in[i*W +: W];
      end else if (coef_commit) begin
        commit_pending <= 1'b1;
      end
      if (frame_strobe && busy) overrun <= 1'b1;
      if (store) out_r[bus] <= y;
    end
  end

`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clip_count <= '0;
    else if (clip_clear)
      clip_count <= '0;
    else if (store && clip && (clip_count != 16'hFFFF))
      clip_count <= clip_count + 16'd1;
  end
`endif

  mix_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .sample   (frame[cnt]),
    .gain     (bank[active][{bus, cnt}]),
    .acc_clr  (acc_clr),
    .y        (y),
    .clip     (clip)
  );

endmodule

// File: tb/tb_mix_scheduler.sv
// Randomised self-checking bench for mix_scheduler against a frame-level mixing model.
`timescale 1ns/1ps
module tb_mix_scheduler;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_strobe = 1'b0;
  logic [191:0]  audio_in = '0;
  logic [191:0]  audio_out;
  logic          mix_valid, busy, overrun, coef_wr_ready, commit_pending;
  logic          coef_wr_valid = 1'b0;
  logic [5:0]    coef_wr_addr = '0;
  logic [17:0]   coef_wr_data = '0;
  logic          coef_commit = 1'b0;
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
  logic [15:0]   clip_count;
  logic          clip_clear = 1'b0;
`endif

  always #5 clk = ~clk;

  mix_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .frame_strobe   (frame_strobe),
    .audio_in       (audio_in),
    .audio_out      (audio_out),
    .mix_valid      (mix_valid),
    .busy           (busy),
    .overrun        (overrun),
    .coef_wr_valid  (coef_wr_valid),
    .coef_wr_ready  (coef_wr_ready),
    .coef_wr_addr   (coef_wr_addr),
    .coef_wr_data   (coef_wr_data),
    .coef_commit    (coef_commit),
    .commit_pending (commit_pending)
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
    ,
    .clip_count     (clip_count),
    .clip_clear     (clip_clear)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: two gain banks as real integers, which one is live,
  // pending commit, sticky overrun and the clip tally.
  int m_bank [2][64];
  int m_active, m_pending, m_overrun, m_clip;
  int samp  [8];
  int g_tab [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx18(input int raw);
    logic signed [17:0] t;
    t = raw[17:0];
    return int'(t);
  endfunction

  function automatic int rand24();
    logic signed [23:0] t;
    t = 24'($urandom);
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) m_bank[b][i] = 0;
    m_active  = 0;
    m_pending = 0;
    m_overrun = 0;
    m_clip    = 0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_wr_valid = 1'b1;
    coef_wr_addr  = a[5:0];
    coef_wr_data  = d[17:0];
    step();
    coef_wr_valid = 1'b0;
    m_bank[1 - m_active][a] = sx18(d);
  endtask

  task automatic load_bank();
    for (int i = 0; i < 64; i++) write_coef(i, g_tab[i]);
  endtask

  task automatic do_commit();
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
    m_pending = 1;
    check("commit_pending_set", commit_pending, 1);
  endtask

`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
  task automatic do_clip_clear();
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;
    m_clip = 0;
    check("clip_cleared", clip_count, 0);
  endtask
`endif

  // One frame: model computes the expected mix up front; optional mid-frame
  // second strobe, shadow write and commit at the given cycle numbers (-1 = none).
  task automatic run_frame(input int ovr_at, input int wr_at, input int wr_a,
                           input int wr_d, input int commit_at);
    int          cnt;
    int          nclip;
    longint      s;
    logic [23:0] exp_out [8];
    for (int c = 0; c < 8; c++) audio_in[c*24 +: 24] = 24'(samp[c]);
    if (m_pending != 0) begin
      m_active  = 1 - m_active;
      m_pending = 0;
    end
    nclip = 0;
    for (int b = 0; b < 8; b++) begin
      s = 0;
      for (int c = 0; c < 8; c++)
        s += longint'(m_bank[m_active][b*8 + c]) * longint'(samp[c]);
      s = s >>> 16;
      if (s > 64'sd8388607) begin
        s = 64'sd8388607;
        nclip++;
      end else if (s < -64'sd8388608) begin
        s = -64'sd8388608;
        nclip++;
      end
      exp_out[b] = 24'(s);
    end
    m_clip = (m_clip + nclip > 65535) ? 65535 : m_clip + nclip;

    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    cnt = 1;
    check("load_wr_ready", coef_wr_ready, 0);
    check("load_busy", busy, 1);
    while (!mix_valid && cnt < 200) begin
      if (cnt == ovr_at) begin
        frame_strobe = 1'b1;
        m_overrun = 1;
      end
      if (cnt == wr_at) begin
        coef_wr_valid = 1'b1;
        coef_wr_addr  = wr_a[5:0];
        coef_wr_data  = wr_d[17:0];
        m_bank[1 - m_active][wr_a] = sx18(wr_d);
      end
      if (cnt == commit_at) begin
        coef_commit = 1'b1;
        m_pending = 1;
      end
      step();
      cnt++;
      frame_strobe  = 1'b0;
      coef_wr_valid = 1'b0;
      coef_commit   = 1'b0;
    end
    check("latency", cnt, 90);
    check("done_busy", busy, 0);
    check("overrun", overrun, m_overrun);
    check("commit_pending", commit_pending, m_pending);
    for (int b = 0; b < 8; b++)
      check($sformatf("bus%0d", b), audio_out[b*24 +: 24], exp_out[b]);
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
    check("clip_count", clip_count, m_clip);
`endif
    step();
    check("valid_pulse", mix_valid, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    check("rst_audio_out", audio_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_commit_pending", commit_pending, 0);
    check("rst_wr_ready", coef_wr_ready, 1);
    rst = 1'b1;
    step();

    // Identity matrix
    for (int i = 0; i < 64; i++) g_tab[i] = 0;
    for (int b = 0; b < 8; b++) g_tab[b*8 + b] = 'h10000;
    load_bank();
    do_commit();
    for (int k = 0; k < 8; k++) samp[k] = k * 'h1000;
    run_frame(-1, -1, 0, 0, -1);
    check("identity_bus3", audio_out[3*24 +: 24], 24'h003000);
    check("identity_bus7", audio_out[7*24 +: 24], 24'h007000);

    // All inputs summed into bus0, saturating both ways
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
    do_clip_clear();
`endif
    for (int i = 0; i < 64; i++) g_tab[i] = (i < 8) ? 'h10000 : 0;
    load_bank();
    do_commit();
    for (int k = 0; k < 8; k++) samp[k] = 'h7FFFFF;
    run_frame(-1, -1, 0, 0, -1);
    check("sat_pos_bus0", audio_out[23:0], 24'h7FFFFF);
    for (int k = 0; k < 8; k++) samp[k] = -'h800000;
    run_frame(-1, -1, 0, 0, -1);
    check("sat_neg_bus0", audio_out[23:0], 24'h800000);
`ifdef MIX_SCHEDULER_CLIP_COUNT_EN
    check("clip_count_two", clip_count, 2);
`endif

    // Fractional and negative gains
    for (int i = 0; i < 64; i++) g_tab[i] = 0;
    g_tab[0] = 'h08000;
    g_tab[9] = 'h30000;
    load_bank();
    do_commit();
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    samp[0] = -'h200;
    samp[1] = 'h100;
    run_frame(-1, -1, 0, 0, -1);
    check("half_gain", audio_out[23:0], 24'hFFFF00);
    check("neg_gain", audio_out[47:24], 24'hFFFF00);

    // Atomic commit: uncommitted writes invisible; commit while busy waits
    for (int i = 0; i < 64; i++) g_tab[i] = 0;
    for (int b = 0; b < 8; b++) g_tab[b*8 + b] = 'h10000;
    load_bank();
    do_commit();
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    run_frame(-1, -1, 0, 0, -1);
    run_frame(-1, 30, 0, 'h20000, -1);
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    run_frame(-1, -1, 0, 0, -1);
    run_frame(-1, -1, 0, 0, 50);
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    run_frame(-1, -1, 0, 0, -1);
    check("pending_cleared", commit_pending, 0);

    // Random gains and inputs
    for (int i = 0; i < 64; i++) g_tab[i] = int'($urandom_range(0, 'h3FFFF));
    load_bank();
    do_commit();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) samp[k] = rand24();
      run_frame(-1, -1, 0, 0, -1);
    end

    // Second strobe during a frame
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    run_frame(40, -1, 0, 0, -1);

    // Reset in the middle of the MAC phase
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    repeat (9) step();
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
    check("midframe_commit_pending", commit_pending, 1);
    repeat (19) step();
    rst = 1'b0;
    #1;
    check("abort_audio_out", audio_out, 0);
    check("abort_busy", busy, 0);
    check("abort_mix_valid", mix_valid, 0);
    check("abort_overrun", overrun, 0);
    check("abort_commit_pending", commit_pending, 0);
    check("abort_wr_ready", coef_wr_ready, 1);
    step();
    rst = 1'b1;
    model_reset();
    step();
    for (int k = 0; k < 8; k++) samp[k] = rand24();
    run_frame(-1, -1, 0, 0, -1);
    check("post_reset_silence", audio_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
